// File: rtl/tr_switch_sequencer_pkg.sv
// Shared state encoding and default timing constants for the T/R switch sequencer.
package tr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX_SETTLE = 3'd1,
    TX_ON     = 3'd2,
    RX_SETTLE = 3'd3,
    RX_ON     = 3'd4,
    GUARD     = 3'd5
  } tr_state_t;

  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_GUARD_CYCLES  = 4;
  localparam int DEF_TX_MAX_CYCLES = 1024;
  localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/tr_switch_sequencer_if.sv
// Baseband <-> T/R sequencer control bundle; master is the baseband side, slave the sequencer.
interface tr_switch_sequencer_if;
  logic TxRequest;
  logic TxDone;
  logic RxRequest;
  logic EnableTransmit;
  logic EnableReceive;
  logic TxGrant;
  logic RxValid;
  logic Busy;
  logic Fault;

  modport master (
    output TxRequest, TxDone, RxRequest,
    input  EnableTransmit, EnableReceive, TxGrant, RxValid, Busy, Fault
  );

  modport slave (
    input  TxRequest, TxDone, RxRequest,
    output EnableTransmit, EnableReceive, TxGrant, RxValid, Busy, Fault
  );
endinterface

// File: rtl/tr_switch_sequencer.sv
// T/R front-end sequencer: TX-priority arbitration, settle and break-before-make guard.
// Optional TX_ON watchdog with sticky Fault is built when TR_WATCHDOG_EN is defined.
module tr_switch_sequencer
  import tr_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES,
  parameter int TX_MAX_CYCLES = DEF_TX_MAX_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                  Clock,
  input  logic                  Reset,
  tr_switch_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
`ifdef TR_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TX_LAST     = CNT_W'(TX_MAX_CYCLES - 1);
`endif

  tr_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             en_tx_q, en_rx_q, tx_grant_q, rx_valid_q, busy_q;
  logic             tx_req, rx_req;

  // A faulted transmitter is locked out entirely so RX can keep running.
  assign tx_req = bus.TxRequest & ~fault_q;
  assign rx_req = bus.RxRequest;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_req)      state_d = TX_SETTLE;
        else if (rx_req) state_d = RX_SETTLE;
      end
      TX_SETTLE: begin
        if (!tx_req)                  state_d = GUARD;
        else if (cnt_q == SETTLE_LAST) state_d = TX_ON;
      end
      TX_ON: begin
        if (bus.TxDone || !tx_req) state_d = GUARD;
`ifdef TR_WATCHDOG_EN
        else if (cnt_q == TX_LAST) begin
          state_d = GUARD;
          fault_d = 1'b1;
        end
`endif
      end
      RX_SETTLE: begin
        if (tx_req || !rx_req)         state_d = GUARD;
        else if (cnt_q == SETTLE_LAST) state_d = RX_ON;
      end
      RX_ON: begin
        if (tx_req || !rx_req) state_d = GUARD;
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
      en_tx_q    <= 1'b0;
      en_rx_q    <= 1'b0;
      tx_grant_q <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      en_tx_q    <= (state_d == TX_SETTLE) || (state_d == TX_ON);
      en_rx_q    <= (state_d == RX_SETTLE) || (state_d == RX_ON);
      tx_grant_q <= (state_d == TX_ON);
      rx_valid_q <= (state_d == RX_ON);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.EnableTransmit = en_tx_q;
  assign bus.EnableReceive  = en_rx_q;
  assign bus.TxGrant        = tx_grant_q;
  assign bus.RxValid        = rx_valid_q;
  assign bus.Busy           = busy_q;
  assign bus.Fault          = fault_q;

endmodule

// File: tb/tb_tr_switch_sequencer.sv
// Scoreboard bench for tr_switch_sequencer; the watchdog scenario runs when TR_WATCHDOG_EN is defined.
module tb_tr_switch_sequencer;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  tr_switch_sequencer_if bus ();

  tr_switch_sequencer #(
    .SETTLE_CYCLES(8),
    .GUARD_CYCLES (4),
    .TX_MAX_CYCLES(16),
    .CNT_W        (16)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  // Output vector: {EnableTransmit, EnableReceive, TxGrant, RxValid, Busy, Fault}
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_TXS  = 6'b100010;
  localparam logic [5:0] E_TXON = 6'b101010;
  localparam logic [5:0] E_RXS  = 6'b010010;
  localparam logic [5:0] E_RXON = 6'b010110;
  localparam logic [5:0] E_GRD  = 6'b000010;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [5:0] fmask  = 6'b0;
  logic [5:0] exp_q[$];
  string      name_q[$];

  function automatic logic [5:0] outs();
    return {bus.EnableTransmit, bus.EnableReceive, bus.TxGrant,
            bus.RxValid, bus.Busy, bus.Fault};
  endfunction

  // Drive n cycles of constant inputs; expected post-edge outputs go to the scoreboard.
  task automatic run(input int n, input logic tx, input logic dn, input logic rx,
                     input logic [5:0] e, input string nm);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      bus.TxRequest = tx;
      bus.TxDone    = dn;
      bus.RxRequest = rx;
      @(posedge Clock);
      exp_q.push_back(e | fmask);
      name_q.push_back(nm);
    end
  endtask

  task automatic chk_now(input string nm, input logic [5:0] e);
    n_chk++;
    if (outs() !== e) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, outs(), e);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic pulse_reset(input string nm);
    @(negedge Clock);
    #2;
    Reset         = 1'b1;
    bus.TxRequest = 1'b0;
    bus.TxDone    = 1'b0;
    bus.RxRequest = 1'b0;
    #1;
    chk_now(nm, E_IDLE);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    fmask = 6'b0;
  endtask

  // Scoreboard monitor plus the mutual-exclusion invariant.
  initial begin
    logic [5:0] e;
    string      nm;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_chk++;
        if (outs() !== e) begin
          n_fail++;
          $display("FAIL %s: got %b want %b at %0t", nm, outs(), e, $time);
        end
      end
      n_chk++;
      if (bus.EnableTransmit === 1'b1 && bus.EnableReceive === 1'b1) begin
        n_fail++;
        $display("FAIL enable_exclusive: got tx=1 rx=1 want not both at %0t", $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish want finish within 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.TxRequest = 1'b0;
    bus.TxDone    = 1'b0;
    bus.RxRequest = 1'b0;
    #1 Reset = 1'b1;
    #1 chk_now("reset_state", E_IDLE);
    @(negedge Clock);
    Reset = 1'b0;

    // TX request from IDLE: 8 settle cycles, grant, then TxDone with request still high.
    run(2, 0, 0, 0, E_IDLE, "idle");
    run(8, 1, 0, 0, E_TXS,  "tx_settle");
    run(3, 1, 0, 0, E_TXON, "tx_on");
    run(1, 1, 1, 0, E_GRD,  "txdone_guard");
    run(3, 0, 0, 0, E_GRD,  "guard_hold");
    run(1, 0, 0, 0, E_IDLE, "guard_exit");
    run(1, 0, 1, 0, E_IDLE, "txdone_in_idle");
    run(1, 0, 0, 0, E_IDLE, "idle_after_done");

    // Simultaneous requests: TX wins, RX served after guard.
    run(8, 1, 0, 1, E_TXS,  "both_tx_settle");
    run(2, 1, 0, 1, E_TXON, "both_tx_on");
    run(1, 0, 0, 1, E_GRD,  "tx_release");
    run(3, 0, 0, 1, E_GRD,  "guard_ignores_rx");
    run(1, 0, 0, 1, E_IDLE, "guard_to_idle");
    run(8, 0, 0, 1, E_RXS,  "rx_settle");
    run(3, 0, 0, 1, E_RXON, "rx_on");

    // TX preempts RX_ON: 4 guard cycles, then TX path settles.
    run(1, 1, 0, 1, E_GRD,  "preempt_guard");
    run(3, 1, 0, 1, E_GRD,  "preempt_hold");
    run(1, 1, 0, 0, E_IDLE, "preempt_idle");
    run(8, 1, 0, 0, E_TXS,  "preempt_tx_settle");
    run(2, 1, 0, 0, E_TXON, "preempt_tx_on");
    run(1, 0, 0, 0, E_GRD,  "txreq_drop");
    run(3, 0, 0, 0, E_GRD,  "guard_hold2");
    run(1, 0, 0, 0, E_IDLE, "guard_exit2");

    // TX request withdrawn in the 3rd settle cycle: no grant.
    run(2, 1, 0, 0, E_TXS,  "abort_settle");
    run(1, 0, 0, 0, E_GRD,  "abort_guard");
    run(3, 0, 0, 0, E_GRD,  "abort_hold");
    run(1, 0, 0, 0, E_IDLE, "abort_idle");

    // Reset in the middle of TX_ON.
    run(8, 1, 0, 0, E_TXS,  "pre_reset_settle");
    run(2, 1, 0, 0, E_TXON, "pre_reset_on");
    pulse_reset("reset_mid_tx_on");
    run(2, 0, 0, 0, E_IDLE, "post_reset_idle");

`ifdef TR_WATCHDOG_EN
    // Watchdog: 16 TX_ON cycles without release -> guard + sticky fault.
    run(8,  1, 0, 0, E_TXS,  "wd_settle");
    run(16, 1, 0, 0, E_TXON, "wd_tx_on");
    fmask = 6'b000001;
    run(1, 1, 0, 0, E_GRD,  "wd_trip");
    run(3, 1, 0, 0, E_GRD,  "wd_guard");
    run(4, 1, 0, 0, E_IDLE, "wd_tx_ignored");
    run(8, 0, 0, 1, E_RXS,  "wd_rx_settle");
    run(2, 0, 0, 1, E_RXON, "wd_rx_on");
    run(1, 0, 0, 0, E_GRD,  "wd_rx_release");
    run(3, 0, 0, 0, E_GRD,  "wd_guard2");
    run(1, 0, 0, 0, E_IDLE, "wd_idle");
    pulse_reset("wd_reset_clears");
    run(1, 0, 0, 0, E_IDLE, "wd_fault_cleared");
`endif

    run(1, 0, 0, 0, E_IDLE, "final_idle");
    @(negedge Clock);
    @(negedge Clock);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
